uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single byte-wide UART transmitter (`uart_tx` plus its baud generator) among up to `NREQ` byte sources, e.g. the ADC sample formatter and the text/status message generator. It grants the transmitter round-robin and issues one start pulse per byte. It holds a grant across a whole line so text lines terminated by 8'h0A never interleave. It also watches the transmitter's busy flag and flags a stalled transmitter.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..8.
- `BUSY_TMO`, 16: maximum cycles from `tx_start` to `tx_busy` rising before the timeout fires; range 2..255.
- `EOL`, 8'h0A: terminator byte that releases a line lock.

- `RST_clk` in 1: system clock; all logic is on the rising edge.
- `RST_n` in 1: asynchronous active-low reset.
- `req` in NREQ: per-source request; level; held high while a byte is pending.
- `req_data` in 8*NREQ: byte k is `req_data[8k+7:8k]`; stable while `req[k]`=1 and no ack.
- `ack` out NREQ: one-hot, one-cycle pulse; byte accepted.
- `tx_data` out 8: byte to the transmitter; held from load until next load.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_busy` in 1: transmitter busy; high for the whole frame.
- `owner` out clog2(NREQ): index of the last granted source.
- `locked` out 1: grant is held for a line in progress.
- `err_tmo` out 1: sticky; the transmitter failed to go busy.

## Operation
- States: IDLE, START, WAIT_HI, WAIT_LO.
- Round-robin pointer `last`. Search order is `last`+1, `last`+2, … modulo NREQ. The first `req` found wins.
- IDLE, any `req` high, at the edge:
  - If `locked`=1 and `req[owner]`=1, choose `owner`.
  - If `locked`=1 and `req[owner]`=0, clear `locked` and choose by round-robin in the same cycle.
  - Otherwise choose by round-robin.
  - Load `tx_data` with the chosen byte.
  - Set `owner`=`last`=choice.
  - Set `locked`=1 if byte != EOL, else `locked`=0.
  - Go to START.
- START: `tx_start`=1 and `ack[owner]`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_HI.
- WAIT_HI:
  - If `tx_busy`=1, go to WAIT_LO.
  - If the counter reaches BUSY_TMO with `tx_busy` still 0: set `err_tmo`, clear `locked`, go to IDLE. The byte is lost; ack was already given.
- WAIT_LO: if `tx_busy`=0, go to IDLE. There is no timeout in this state.
- IDLE with no `req` high: hold. `tx_start`=0 and `ack`=0.
- `err_tmo` is cleared only by reset. Arbitration continues while it is set.
- A requester dropping `req` while ungranted is legal. A requester changing `req_data` without ack is undefined for that byte only.
- The arbiter does not inspect `req` outside IDLE.

## Timing
- Reset values (asynchronous):
  - state=IDLE
  - `tx_start`=0, `ack`=0, `tx_data`=8'h00
  - `owner`=0, `locked`=0, `err_tmo`=0
  - `last`=NREQ-1, so source 0 has first priority.
- All outputs are registered.
- Latency: `req` high at edge n in IDLE gives `tx_start` and `ack` high in cycle n+1.
- Data is captured at edge n. The requester may present the next byte from cycle n+2 on.
- Back-to-back bytes: the next START comes 2 cycles after `tx_busy` falls (WAIT_LO→IDLE, then IDLE→START).
- Simultaneous requests: exactly one ack per START. The others wait with no loss.
- Timeout fires on the BUSY_TMO-th cycle after START. `err_tmo` is high the following cycle.
- `tx_busy` already high in START: WAIT_HI exits on its first cycle.
- Reset mid-frame:
  - All outputs return to reset values immediately.
  - The transmitter is reset by the same `RST_n`.
  - Any partially granted line is abandoned.

## Test plan
- Single source 0 sends 'h','i',8'h0A; transmitter model busy for 100 cycles after each start:
  - exactly 3 `tx_start` pulses, `tx_data` 8'h68, 8'h69, 8'h0A
  - `locked`=1 after 'h' and after 'i'; `locked`=0 after 8'h0A
  - each ack is 1 cycle after req is seen in IDLE.
- Sources 0, 1 and 2 each request one EOL byte (8'h0A) simultaneously from reset:
  - grant order 0,1,2
  - then source 2 and source 0 re-request: order 0,2.
- Source 1 sends "ab\n" while source 3 requests continuously:
  - `tx_data` sequence 8'h61, 8'h62, 8'h0A
  - source 3 is served only after 8'h0A.
- Source 1 sends 'a' then drops `req`; source 2 requests:
  - at the next IDLE the lock is released and source 2 is granted
  - `locked` follows source 2's byte.
- `tx_busy` tied 0, source 0 requests:
  - `err_tmo` rises 16 cycles after `tx_start`
  - a new START follows, since `req` is still high
  - `err_tmo` stays 1 until `RST_n`=0.
- Assert `RST_n`=0 in WAIT_LO during a locked line: all outputs are at reset values before the next clock edge, and `locked`=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter among NREQ sources.
// Holds the grant for a source until it sends EOL and flags a transmitter that never goes busy.
module uart_tx_arbiter #(
  parameter int         NREQ     = 4,
  parameter int         BUSY_TMO = 16,
  parameter logic [7:0] EOL      = 8'h0A
) (
  input  logic                    RST_clk,
  input  logic                    RST_n,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         ack,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    locked,
  output logic                    err_tmo
);
  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  state_t          state, nxt_state;
  logic [OW-1:0]   last, nxt_last, nxt_owner;
  logic [OW-1:0]   rr_idx, rr_pick, pick;
  logic            rr_hit;
  logic [7:0]      cnt, nxt_cnt, nxt_tx_data, pick_byte;
  logic [NREQ-1:0] nxt_ack;
  logic            nxt_tx_start, nxt_locked, nxt_err;

  // First requester after `last`, wrapping; `last` itself is checked last.
  always_comb begin
    rr_idx  = '0;
    rr_pick = last;
    rr_hit  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      rr_idx = OW'((int'(last) + i) % NREQ);
      if (!rr_hit && req[rr_idx]) begin
        rr_hit  = 1'b1;
        rr_pick = rr_idx;
      end
    end
  end

  // A locked owner that still requests keeps the line; otherwise the lock is dropped.
  assign pick      = (locked && req[owner]) ? owner : rr_pick;
  assign pick_byte = req_data[{pick, 3'b000} +: 8];

  always_comb begin
    nxt_state    = state;
    nxt_tx_start = 1'b0;
    nxt_ack      = '0;
    nxt_tx_data  = tx_data;
    nxt_owner    = owner;
    nxt_last     = last;
    nxt_locked   = locked;
    nxt_err      = err_tmo;
    nxt_cnt      = cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          nxt_tx_data  = pick_byte;
          nxt_owner    = pick;
          nxt_last     = pick;
          nxt_locked   = (pick_byte != EOL);
          nxt_tx_start = 1'b1;
          nxt_ack      = NREQ'(1) << pick;
          nxt_state    = START;
        end
      end
      START: begin
        nxt_cnt   = '0;
        nxt_state = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          nxt_state = WAIT_LO;
        end else if (cnt == 8'(BUSY_TMO - 1)) begin
          // Byte already acked; it is dropped and any line lock is abandoned.
          nxt_err    = 1'b1;
          nxt_locked = 1'b0;
          nxt_state  = IDLE;
        end else begin
          nxt_cnt = cnt + 8'd1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge RST_clk or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      ack      <= '0;
      tx_data  <= '0;
      owner    <= '0;
      last     <= OW'(NREQ - 1);
      locked   <= 1'b0;
      err_tmo  <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= nxt_state;
      tx_start <= nxt_tx_start;
      ack      <= nxt_ack;
      tx_data  <= nxt_tx_data;
      owner    <= nxt_owner;
      last     <= nxt_last;
      locked   <= nxt_locked;
      err_tmo  <= nxt_err;
      cnt      <= nxt_cnt;
    end
  end

endmodule
